// File: rtl/mem_model_pkg.sv
// Shared helpers and types for the memory delay model.
package mem_model_pkg;

    typedef enum logic [1:0] {
        ERR_NONE,
        ERR_RW_BOTH,
        ERR_BAD_SIZE
    } err_cause_e;

    function automatic int clog2(input int unsigned value);
        int r;
        r = 0;
        while ((64'd1 << r) < 64'(value)) begin
            r++;
        end
        return r;
    endfunction

    // Width of data_size: must be able to hold DATA_W itself.
    function automatic int sz_w(input int data_w);
        return clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/mem_delay_chan.sv
// Per-channel range check, protocol check and latency counter.
// Latency: data_rdy when cnt reaches RD_DELAY-1 / WR_DELAY-1 (combinational in that cycle).
// Backpressure: none; master holds oe/we until data_rdy, dropping the request abandons it.
module mem_delay_chan
    import mem_model_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 256,
    parameter int                RD_DELAY  = 2,
    parameter int                WR_DELAY  = 1,
    localparam int               SZ_W      = sz_w(DATA_W),
    localparam int               OFF_W     = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              oe,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [SZ_W-1:0]   data_size,
    output logic              data_rdy,
    output logic              rd_fire,
    output logic              wr_fire,
    output logic [OFF_W-1:0]  offset,
    output logic [SZ_W-1:0]   nbytes,
    output logic              err
);

    localparam int MAX_DLY = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
    localparam int CNT_W   = clog2(MAX_DLY) + 1;

    logic [CNT_W-1:0] cnt;
    err_cause_e       cause;
    logic             size_ok;
    logic             in_range;
    logic             active;
    logic             last;
    logic [ADDR_W:0]  end_addr;
    logic [ADDR_W:0]  limit;

    always_comb begin
        size_ok  = (data_size != '0) && (data_size <= SZ_W'(DATA_W)) &&
                   ((data_size & (data_size - SZ_W'(1))) == '0);
        cause    = ERR_NONE;
        if (oe && we) begin
            cause = ERR_RW_BOTH;
        end else if ((oe || we) && !size_ok) begin
            cause = ERR_BAD_SIZE;
        end
        nbytes   = data_size >> 3;
        // addr + nbytes <= limit is addr + nbytes - 1 < limit without the underflow.
        end_addr = {1'b0, addr} + (ADDR_W+1)'(nbytes);
        limit    = {1'b0, BASE_ADDR} + (ADDR_W+1)'(DEPTH);
        in_range = (addr >= BASE_ADDR) && (end_addr <= limit);
        active   = (oe || we) && (cause == ERR_NONE) && in_range;
        last     = oe ? (cnt == CNT_W'(RD_DELAY - 1)) : (cnt == CNT_W'(WR_DELAY - 1));
        data_rdy = reset && active && last;
        rd_fire  = data_rdy && oe;
        wr_fire  = data_rdy && we;
        offset   = OFF_W'(addr - BASE_ADDR);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (cause != ERR_NONE) begin
                err <= 1'b1;
            end
            if (!active || data_rdy) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_delay_model.sv
// Multi-channel byte-addressed memory slave with fixed read/write latency.
// Latency: RD_DELAY / WR_DELAY cycles from request to data_rdy; writes land on the data_rdy edge.
// Backpressure: none; out-of-range channels stay silent so several slaves can share a bus.
module mem_delay_model
    import mem_model_pkg::*;
#(
    parameter int                N_CH      = 2,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 256,
    parameter int                RD_DELAY  = 2,
    parameter int                WR_DELAY  = 1,
    localparam int               SZ_W      = sz_w(DATA_W)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [N_CH-1:0]          oe,
    input  logic [N_CH-1:0]          we,
    input  logic [N_CH*ADDR_W-1:0]   addr,
    input  logic [N_CH*DATA_W-1:0]   wdata,
    input  logic [N_CH*SZ_W-1:0]     data_size,
    output logic [N_CH*DATA_W-1:0]   rdata,
    output logic [N_CH-1:0]          data_rdy,
    output logic [N_CH-1:0]          err
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

    // Contents survive reset; only power-up clears them.
    logic [7:0]       mem [DEPTH] = '{default: 8'h00};
    logic [N_CH-1:0]  rd_fire;
    logic [N_CH-1:0]  wr_fire;
    logic [OFF_W-1:0] offset [N_CH];
    logic [SZ_W-1:0]  nbytes [N_CH];

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        mem_delay_chan #(
            .ADDR_W    (ADDR_W),
            .DATA_W    (DATA_W),
            .BASE_ADDR (BASE_ADDR),
            .DEPTH     (DEPTH),
            .RD_DELAY  (RD_DELAY),
            .WR_DELAY  (WR_DELAY)
        ) u_chan (
            .clock     (clock),
            .reset     (reset),
            .oe        (oe[i]),
            .we        (we[i]),
            .addr      (addr[i*ADDR_W +: ADDR_W]),
            .data_size (data_size[i*SZ_W +: SZ_W]),
            .data_rdy  (data_rdy[i]),
            .rd_fire   (rd_fire[i]),
            .wr_fire   (wr_fire[i]),
            .offset    (offset[i]),
            .nbytes    (nbytes[i]),
            .err       (err[i])
        );
    end

    // Later channels overwrite earlier ones, so the highest index wins a byte collision.
    always_ff @(posedge clock) begin
        for (int i = 0; i < N_CH; i++) begin
            if (wr_fire[i]) begin
                for (int b = 0; b < NB; b++) begin
                    if (SZ_W'(b) < nbytes[i]) begin
                        mem[offset[i] + OFF_W'(b)] <= wdata[i*DATA_W + b*8 +: 8];
                    end
                end
            end
        end
    end

    // Combinational read sees the array before this edge's writes.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd_fire[i]) begin
                for (int b = 0; b < NB; b++) begin
                    if (SZ_W'(b) < nbytes[i]) begin
                        rdata[i*DATA_W + b*8 +: 8] = mem[offset[i] + OFF_W'(b)];
                    end
                end
            end
        end
    end

endmodule

// File: doc/mem_delay_model.md
MEM_DELAY_MODEL -- requirements
Module: mem_delay_model

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent master channels.
REQ-002 SHALL have parameter ADDR_W, default 32: address width per channel, byte-addressed.
REQ-003 SHALL have parameter DATA_W, default 8: data width per channel in bits, a multiple of 8.
REQ-004 SHALL have parameter BASE_ADDR, default 0: first byte address owned by the model.
REQ-005 SHALL have parameter DEPTH, default 256: number of bytes owned, covering [BASE_ADDR, BASE_ADDR+DEPTH).
REQ-006 SHALL have parameters RD_DELAY (default 2) and WR_DELAY (default 1), each at least 1, giving the cycles from request to data_rdy.
REQ-007 SHALL define SZ_W = clog2(DATA_W)+1.
REQ-008 SHALL have port clock, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port oe, input, N_CH bits: per-channel read request.
REQ-011 SHALL have port we, input, N_CH bits: per-channel write request.
REQ-012 SHALL have port addr, input, N_CH*ADDR_W bits: per-channel byte address; channel i occupies slice i.
REQ-013 SHALL have port wdata, input, N_CH*DATA_W bits: per-channel write data.
REQ-014 SHALL have port data_size, input, N_CH*SZ_W bits: per-channel access size in bits, one of 8, 16, 32 and so on, up to DATA_W.
REQ-015 SHALL have port rdata, output, N_CH*DATA_W bits: per-channel read data; zero unless that channel's data_rdy is high.
REQ-016 SHALL have port data_rdy, output, N_CH bits: per-channel one-cycle completion pulse.
REQ-017 SHALL have port err, output, N_CH bits: sticky per-channel protocol-error flags.

Function
REQ-018 A channel SHALL be "in range" when addr >= BASE_ADDR and addr+data_size/8-1 < BASE_ADDR+DEPTH; out-of-range channels SHALL hold their counter at 0, give data_rdy=0 and rdata=0, so other slaves can be OR-combined on the same bus.
REQ-019 Each channel SHALL hold a latency counter cnt that increments on every edge while an in-range oe or we is held, and clears to 0 on the edge where data_rdy is high or where the request drops.
REQ-020 A read SHALL assert data_rdy combinationally when cnt == RD_DELAY-1; with RD_DELAY=1 this is the first cycle of the request.
REQ-021 A write SHALL assert data_rdy combinationally when cnt == WR_DELAY-1.
REQ-022 A master holding a request after data_rdy SHALL start a new transaction, with the counter restarting from 0.
REQ-023 On a read, rdata SHALL carry the data_size/8 bytes from addr-BASE_ADDR upward in little-endian order, with the upper bits zero.
REQ-024 A write SHALL update only the data_size/8 low bytes of wdata, and only at the rising edge where data_rdy is high.
REQ-025 When two channels write the same byte on the same edge, the higher channel index SHALL win.
REQ-026 When a read completes on the same edge as a write to the same byte, the read SHALL return the old data.
REQ-027 If oe and we are both high on a channel, or data_size is 0, greater than DATA_W, or not a power of two: err[i] SHALL set, the access SHALL be ignored (no data_rdy, no write), and cnt SHALL stay 0.
REQ-028 err SHALL stay set until reset.
REQ-029 A request dropped before completion SHALL be abandoned, with no memory side effect.

Reset
REQ-030 While reset is low, cnt, data_rdy, rdata and err SHALL be 0 immediately, regardless of clock.
REQ-031 The memory array SHALL NOT be reset; it SHALL initialise to zero at time 0 and keep its contents across reset.
REQ-032 A reset during a transaction SHALL abandon it with no write performed.
REQ-033 Counting SHALL resume on the first rising edge after reset is released.

Structure
REQ-034 Package mem_model_pkg SHALL hold the SZ_W function, the clog2 helper, and the error-cause enum: ERR_NONE, ERR_RW_BOTH, ERR_BAD_SIZE.
REQ-035 The per-channel counter, range check and handshake SHALL be one sub-module, mem_delay_chan, instantiated N_CH times.
REQ-036 The byte array and write arbitration SHALL live in the top module.

Verification
REQ-037 Default parameters: ch0 oe with addr=0x10, size 8, where byte 0x10 = 0xA5 -> data_rdy[0] in the second cycle, rdata[7:0]=0xA5, and 0 in every other cycle.
REQ-038 RD_DELAY=1, DATA_W=32: read 32 bits at 0x20 holding bytes 11,22,33,44 -> same-cycle data_rdy, rdata=0x44332211.
REQ-039 Writes on ch0 and ch1 on the same edge to 0x05 with 0x11 and 0x22 -> a later read returns 0x22; a 16-bit write of 0xBEEF at 0x08 with DATA_W=32 -> only bytes 0x08 and 0x09 change.
REQ-040 ch1 addr=BASE_ADDR+DEPTH with oe held 10 cycles -> data_rdy[1]=0, rdata=0, err[1]=0 throughout.
REQ-041 ch0 oe and we high together -> err[0]=1 on the next edge, memory unchanged, err stays 1 until reset pulses low asynchronously mid-cycle, then clears immediately.
REQ-042 Read of 0x30 (old 0x00) completing on the same edge as a ch1 write of 0x77 to 0x30 -> read returns 0x00; a subsequent read returns 0x77.
